// File: rtl/procesador_pkg.sv
// rtl/procesador_pkg.sv - shared types, opcode/condition constants and helpers for the multi-cycle core
package procesador_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } estado_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_HALT = 4'b1111;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic cond_pass(input logic [3:0] cond, input nzcv_t f);
    logic pass;
    case (cond)
      COND_EQ: pass = f.z;
      COND_NE: pass = !f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = !f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = !f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = !f.v;
      COND_HI: pass = f.c && !f.z;
      COND_LS: pass = !f.c || f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = !f.z && (f.n == f.v);
      COND_LE: pass = f.z || (f.n != f.v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Rotate right by 2*rot: shift a doubled copy and keep the low word
  function automatic logic [31:0] rot_imm(input logic [3:0] rot, input logic [7:0] imm8);
    logic [63:0] dbl;
    dbl = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/banco_registros.sv
// rtl/banco_registros.sv - R0-R14 register file, two read ports, one write port, debug read
module banco_registros
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] regs [15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (we && waddr != 4'd15) begin
      regs[waddr] <= wdata;
    end
  end

  // R15 lives in the core as the PC; the top substitutes it
  assign rdata_a  = (raddr_a  == 4'd15) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b  == 4'd15) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_addr == 4'd15) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/procesador_multiciclo.sv
// rtl/procesador_multiciclo.sv - multi-cycle ARM-subset core on a unified req/ack memory
module procesador_multiciclo
  import procesador_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              halted,
  input  logic [3:0]        dbg_addr,
  output logic [31:0]       dbg_data
);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] pc_q, addr_q;
  logic [31:0]       ir_q, a_q, b_q, res_q;
  nzcv_t             flags_q;
  logic              wr_q;

  logic [3:0]  cond, cmd, rn, rd, rm;
  logic [1:0]  op;
  logic        imm_f, s_f, u_f, l_f, ack;
  logic [11:0] imm12;
  logic [23:0] imm24;

  assign cond  = ir_q[31:28];
  assign op    = ir_q[27:26];
  assign imm_f = ir_q[25];
  assign cmd   = ir_q[24:21];
  assign u_f   = ir_q[23];
  assign s_f   = ir_q[20];
  assign l_f   = ir_q[20];
  assign rn    = ir_q[19:16];
  assign rd    = ir_q[15:12];
  assign rm    = ir_q[3:0];
  assign imm12 = ir_q[11:0];
  assign imm24 = ir_q[23:0];

  logic [31:0] rf_a, rf_b, rf_dbg, pc8, rn_val, rb_val;
  logic [3:0]  raddr_b;

  // Stores need Rd on the second port; data-processing needs Rm
  assign raddr_b = (op == OP_MEM) ? rd : rm;
  // PC already points past the instruction, so +4 gives instruction address + 8
  assign pc8     = 32'(pc_q) + 32'd4;
  assign rn_val  = (rn == 4'd15) ? pc8 : rf_a;
  assign rb_val  = (raddr_b == 4'd15) ? pc8 : rf_b;

  banco_registros u_regs (
    .clk      (clk),
    .rst_n    (rst),
    .raddr_a  (rn),
    .raddr_b  (raddr_b),
    .rdata_a  (rf_a),
    .rdata_b  (rf_b),
    .we       (state_q == S_WB && wr_q && rd != 4'd15),
    .waddr    (rd),
    .wdata    (res_q),
    .dbg_addr (dbg_addr),
    .dbg_data (rf_dbg)
  );

  logic [31:0] op2, alu_res;
  logic [32:0] add33, sub33;
  nzcv_t       alu_flags;
  logic        alu_wr, alu_setf;

  assign op2   = imm_f ? rot_imm(ir_q[11:8], ir_q[7:0]) : b_q;
  assign add33 = {1'b0, a_q} + {1'b0, op2};
  assign sub33 = {1'b0, a_q} + {1'b0, ~op2} + 33'd1;

  always_comb begin
    alu_res   = '0;
    alu_flags = flags_q;
    alu_wr    = 1'b0;
    alu_setf  = 1'b0;
    case (cmd)
      CMD_AND: begin alu_res = a_q & op2; alu_wr = 1'b1; alu_setf = s_f; end
      CMD_ORR: begin alu_res = a_q | op2; alu_wr = 1'b1; alu_setf = s_f; end
      CMD_MOV: begin alu_res = op2;       alu_wr = 1'b1; alu_setf = s_f; end
      CMD_ADD: begin
        alu_res     = add33[31:0];
        alu_flags.c = add33[32];
        alu_flags.v = (a_q[31] == op2[31]) && (add33[31] != a_q[31]);
        alu_wr      = 1'b1;
        alu_setf    = s_f;
      end
      CMD_SUB, CMD_CMP: begin
        alu_res     = sub33[31:0];
        alu_flags.c = sub33[32];
        alu_flags.v = (a_q[31] != op2[31]) && (sub33[31] != a_q[31]);
        alu_wr      = (cmd == CMD_SUB);
        alu_setf    = s_f || (cmd == CMD_CMP);
      end
      default: ;
    endcase
    alu_flags.n = alu_res[31];
    alu_flags.z = (alu_res == 32'd0);
  end

  logic [ADDR_W-1:0] mem_ea, br_off;
  assign mem_ea = u_f ? ADDR_W'(a_q) + ADDR_W'(imm12) : ADDR_W'(a_q) - ADDR_W'(imm12);
  assign br_off = ADDR_W'({{6{imm24[23]}}, imm24, 2'b00});

  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && !l_f;
  assign mem_addr  = (state_q == S_MEM) ? addr_q : pc_q;
  assign mem_wdata = b_q;
  assign ack       = mem_req && mem_ack;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_data  = (dbg_addr == 4'd15) ? 32'(pc_q) : rf_dbg;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        if (ack) state_d = S_DECODE;
      S_DECODE: begin
        if (cond == COND_HALT)            state_d = S_HALT;
        else if (!cond_pass(cond, flags_q)) state_d = S_FETCH;
        else                              state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_DP:   state_d = S_WB;
          OP_MEM:  state_d = S_MEM;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM:   if (ack) state_d = l_f ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: if (ack) begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + ADDR_W'(4);
        end
        S_DECODE: begin
          a_q <= rn_val;
          b_q <= rb_val;
        end
        S_EXEC: begin
          case (op)
            OP_DP: begin
              res_q <= alu_res;
              wr_q  <= alu_wr;
              if (alu_setf) flags_q <= alu_flags;
            end
            OP_MEM: begin
              addr_q <= mem_ea & ~ADDR_W'(3);
              wr_q   <= l_f;
            end
            OP_BR:   pc_q <= pc_q + ADDR_W'(4) + br_off;
            default: wr_q <= 1'b0;
          endcase
        end
        S_MEM: if (ack && l_f) res_q <= mem_rdata;
        S_WB:  if (wr_q && rd == 4'd15) pc_q <= ADDR_W'(res_q) & ~ADDR_W'(3);
        default: ;
      endcase
    end
  end

endmodule
